// File: rtl/dot_pkg.sv
// ============================================================================
// Module   : dot_pkg
// Brief    : Shared constants and FSM state encoding for the dot update path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CENTRE_X = 320;
  localparam int CENTRE_Y = 240;
  localparam int DEF_X_W  = 10;
  localparam int DEF_Y_W  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SEND_X = 2'd2,
    SEND_Y = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dot_shadow_table.sv
// ============================================================================
// Module   : dot_shadow_table
// Brief    : Shadow X/Y position table with per-entry dirty bits. Optional
//            coordinate clamping is enabled by defining DOT_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_shadow_table
  import dot_pkg::*;
#(
  parameter int NUM_DOTS = 200,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  localparam int IDX_W   = $clog2(NUM_DOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_is_y,
  input  logic [31:0]      wr_id,
  input  logic [31:0]      wr_data,
  output logic             wr_bad,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_dirty,
  output logic             any_dirty,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [X_W-1:0]      x_q     [NUM_DOTS];
  logic [X_W-1:0]      x_d     [NUM_DOTS];
  logic [Y_W-1:0]      y_q     [NUM_DOTS];
  logic [Y_W-1:0]      y_d     [NUM_DOTS];
  logic [NUM_DOTS-1:0] dirty_q;
  logic [NUM_DOTS-1:0] dirty_d;

  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;

  assign wr_ok  = wr_en && (wr_id < 32'(NUM_DOTS));
  assign wr_bad = wr_en && !(wr_id < 32'(NUM_DOTS));
  assign wr_idx = wr_id[IDX_W-1:0];

`ifdef DOT_CLAMP_EN
  assign wr_x = (wr_data > 32'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : wr_data[X_W-1:0];
  assign wr_y = (wr_data > 32'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : wr_data[Y_W-1:0];
`else
  assign wr_x = wr_data[X_W-1:0];
  assign wr_y = wr_data[Y_W-1:0];
`endif

  // Write is applied after the clear so a same-cycle write keeps the entry dirty.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dirty_d = dirty_q;
    if (clr_en) begin
      dirty_d[clr_idx] = 1'b0;
    end
    if (wr_ok) begin
      if (wr_is_y) begin
        y_d[wr_idx] = wr_y;
      end else begin
        x_d[wr_idx] = wr_x;
      end
      dirty_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        x_q[i] <= X_W'(CENTRE_X);
        y_q[i] <= Y_W'(CENTRE_Y);
      end
      dirty_q <= '1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];
  assign rd_dirty  = dirty_q[rd_idx];
  assign any_dirty = |dirty_q;

endmodule

`default_nettype wire

// File: rtl/dot_update_sequencer.sv
// ============================================================================
// Module   : dot_update_sequencer
// Brief    : Streams dirty dot positions to the VGA write port on each frame
//            end, holding each write for the slow pixel clock. Optional
//            coordinate clamping via DOT_CLAMP_EN (in dot_shadow_table).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_update_sequencer
  import dot_pkg::*;
#(
  parameter int NUM_DOTS    = 200,
  parameter int HOLD_CYCLES = 4,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic        cpu_is_y,
  input  logic [31:0] cpu_id,
  input  logic [31:0] cpu_data,
  output logic        cpu_err,
  input  logic        screen_end,
  output logic        dotWren,
  output logic        is_Yloc,
  output logic [31:0] dotID,
  output logic [31:0] dotLoc,
  output logic        flush_busy,
  output logic        overrun
);

  localparam int IDX_W = $clog2(NUM_DOTS);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [Y_W-1:0]   y_hold_q, y_hold_d;
  logic             dot_wren_q, dot_wren_d;
  logic             is_y_q, is_y_d;
  logic [31:0]      dot_id_q, dot_id_d;
  logic [31:0]      dot_loc_q, dot_loc_d;
  logic             flush_busy_q, flush_busy_d;
  logic             cpu_err_q, cpu_err_d;
  logic             overrun_q, overrun_d;
  logic             rewritten_q, rewritten_d;
  logic             se_s1_q, se_s1_d, se_s2_q, se_s2_d, se_s3_q, se_s3_d;

  logic           wr_bad, rd_dirty, any_dirty, clr_en;
  logic [X_W-1:0] rd_x;
  logic [Y_W-1:0] rd_y;
  logic           se_rise, wr_hit, last_idx, hold_done;

  dot_shadow_table #(
    .NUM_DOTS (NUM_DOTS),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (cpu_we),
    .wr_is_y   (cpu_is_y),
    .wr_id     (cpu_id),
    .wr_data   (cpu_data),
    .wr_bad    (wr_bad),
    .rd_idx    (idx_q),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_dirty  (rd_dirty),
    .any_dirty (any_dirty),
    .clr_en    (clr_en),
    .clr_idx   (idx_q)
  );

  assign se_rise   = se_s2_q && !se_s3_q;
  assign wr_hit    = cpu_we && (cpu_id == 32'(idx_q));
  assign last_idx  = (idx_q == IDX_W'(NUM_DOTS - 1));
  assign hold_done = (hold_q == CNT_W'(HOLD_CYCLES - 1));

  always_comb begin
    se_s1_d      = screen_end;
    se_s2_d      = se_s1_q;
    se_s3_d      = se_s2_q;
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    y_hold_d     = y_hold_q;
    dot_wren_d   = dot_wren_q;
    is_y_d       = is_y_q;
    dot_id_d     = dot_id_q;
    dot_loc_d    = dot_loc_q;
    flush_busy_d = flush_busy_q;
    rewritten_d  = rewritten_q;
    clr_en       = 1'b0;
    cpu_err_d    = cpu_err_q || wr_bad;
    overrun_d    = overrun_q || (se_rise && flush_busy_q);

    case (state_q)
      IDLE: begin
        if (se_rise && any_dirty) begin
          state_d      = SCAN;
          idx_d        = '0;
          flush_busy_d = 1'b1;
        end
      end
      SCAN: begin
        if (rd_dirty) begin
          // Snapshot both coordinates now; a write in this cycle must keep the entry dirty.
          y_hold_d    = rd_y;
          dot_loc_d   = 32'(rd_x);
          dot_id_d    = 32'(idx_q);
          dot_wren_d  = 1'b1;
          is_y_d      = 1'b0;
          hold_d      = '0;
          rewritten_d = wr_hit;
          state_d     = SEND_X;
        end else if (last_idx) begin
          state_d      = IDLE;
          flush_busy_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND_X: begin
        rewritten_d = rewritten_q || wr_hit;
        if (hold_done) begin
          hold_d    = '0;
          is_y_d    = 1'b1;
          dot_loc_d = 32'(y_hold_q);
          state_d   = SEND_Y;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SEND_Y: begin
        rewritten_d = rewritten_q || wr_hit;
        if (hold_done) begin
          clr_en     = !(rewritten_q || wr_hit);
          dot_wren_d = 1'b0;
          hold_d     = '0;
          if (last_idx) begin
            state_d      = IDLE;
            flush_busy_d = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      se_s1_q      <= 1'b0;
      se_s2_q      <= 1'b0;
      se_s3_q      <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      y_hold_q     <= '0;
      dot_wren_q   <= 1'b0;
      is_y_q       <= 1'b0;
      dot_id_q     <= '0;
      dot_loc_q    <= '0;
      flush_busy_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rewritten_q  <= 1'b0;
    end else begin
      se_s1_q      <= se_s1_d;
      se_s2_q      <= se_s2_d;
      se_s3_q      <= se_s3_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      y_hold_q     <= y_hold_d;
      dot_wren_q   <= dot_wren_d;
      is_y_q       <= is_y_d;
      dot_id_q     <= dot_id_d;
      dot_loc_q    <= dot_loc_d;
      flush_busy_q <= flush_busy_d;
      cpu_err_q    <= cpu_err_d;
      overrun_q    <= overrun_d;
      rewritten_q  <= rewritten_d;
    end
  end

  assign dotWren    = dot_wren_q;
  assign is_Yloc    = is_y_q;
  assign dotID      = dot_id_q;
  assign dotLoc     = dot_loc_q;
  assign flush_busy = flush_busy_q;
  assign cpu_err    = cpu_err_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
